// File: rtl/program_memory_fetch.sv
// rtl/program_memory_fetch.sv - instruction ROM fetch with valid/ready request and response FIFO (optional PROGMEM_ERR_TRAP_EN)
module program_memory_fetch #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000,
    parameter int                    RESP_DEPTH   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE    = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_instr,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Program image: word k holds INIT_BASE + k; read-only, no write port.
    logic [DATA_WIDTH-1:0] rom [MEMORY_DEPTH];

    genvar k;
    generate
        for (k = 0; k < MEMORY_DEPTH; k++) begin : g_rom
            assign rom[k] = INIT_BASE + DATA_WIDTH'(k);
        end
    endgenerate

    // Rebase to the text segment; the subtraction wraps modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] fetch_instr;

    assign off = req_addr - BASE_ADDR;
    assign idx = off[IDX_W+1:2];

`ifdef PROGMEM_ERR_TRAP_EN
    logic fetch_err;
    assign fetch_err   = (off[1:0] != 2'b00) || (off[ADDR_WIDTH-1:IDX_W+2] != '0);
    assign fetch_instr = fetch_err ? '0 : rom[idx];
`else
    // Without trapping, low bits are ignored and the index wraps over the ROM.
    logic unused_off;
    assign unused_off  = ^{off[1:0], off[ADDR_WIDTH-1:IDX_W+2]};
    assign fetch_instr = rom[idx];
`endif

    // Response FIFO storage and bookkeeping.
    logic [DATA_WIDTH-1:0] instr_mem [RESP_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem  [RESP_DEPTH];
`ifdef PROGMEM_ERR_TRAP_EN
    logic                  err_mem   [RESP_DEPTH];
`endif
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  ready_q;
    logic                  push;
    logic                  pop;

    assign push       = req_valid && ready_q;
    assign pop        = (count != '0) && resp_ready;
    assign req_ready  = ready_q;
    assign resp_valid = (count != '0);
    assign resp_instr = instr_mem[rd_ptr];
    assign resp_addr  = addr_mem[rd_ptr];
`ifdef PROGMEM_ERR_TRAP_EN
    assign resp_err   = err_mem[rd_ptr];
`else
    assign resp_err   = 1'b0;
`endif

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO write/pop; ready is registered from next occupancy so a pop at full frees the slot a cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                instr_mem[i] <= '0;
                addr_mem[i]  <= '0;
`ifdef PROGMEM_ERR_TRAP_EN
                err_mem[i]   <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= fetch_instr;
                addr_mem[wr_ptr]  <= req_addr;
`ifdef PROGMEM_ERR_TRAP_EN
                err_mem[wr_ptr]   <= fetch_err;
`endif
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end else if (pop && (count == CNT_W'(1))) begin
                // Draining the last entry: copy it forward so the head keeps showing the last response.
                instr_mem[rd_ptr + PTR_W'(1)] <= instr_mem[rd_ptr];
                addr_mem[rd_ptr + PTR_W'(1)]  <= addr_mem[rd_ptr];
`ifdef PROGMEM_ERR_TRAP_EN
                err_mem[rd_ptr + PTR_W'(1)]   <= err_mem[rd_ptr];
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            ready_q <= (count_nxt < CNT_W'(RESP_DEPTH));
        end
    end

endmodule

// File: tb/tb_program_memory_fetch.sv
// tb/tb_program_memory_fetch.sv - randomized and directed check of program_memory_fetch against a queue model
module tb_program_memory_fetch;

    localparam int          DEPTH = 64;
    localparam int          RDEP  = 2;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] IBASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t q[$];
    logic exp_ready;

    program_memory_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] a);
        exp_t        e;
        logic [31:0] o;
        o       = a - BASE;
        e.addr  = a;
        e.err   = 1'b0;
        e.instr = IBASE + ((o / 4) % DEPTH);
`ifdef PROGMEM_ERR_TRAP_EN
        if ((o % 4) != 0 || o >= 4 * DEPTH) begin
            e.err   = 1'b1;
            e.instr = 32'h0;
        end
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: check outputs against the model, apply inputs, advance one clock.
    task automatic cycle(string tag, logic v, logic [31:0] a, logic rr);
        logic popped;
        logic pushed;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".instr"}, 64'(resp_instr), 64'(q[0].instr));
            chk({tag, ".addr"}, 64'(resp_addr), 64'(q[0].addr));
            chk({tag, ".err"}, 64'(resp_err), 64'(q[0].err));
        end
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        popped = rr && (q.size() != 0);
        pushed = v && exp_ready;
        @(posedge clk);
        if (popped) void'(q.pop_front());
        if (pushed) q.push_back(model(a));
        exp_ready = (q.size() < RDEP);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        exp_ready  = 1'b0;

        // 1) reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.resp_instr", 64'(resp_instr), 64'd0);
        chk("rst.resp_addr", 64'(resp_addr), 64'd0);
        chk("rst.resp_err", 64'(resp_err), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.req_ready", 64'(req_ready), 64'd1);
        exp_ready = 1'b1;
        @(negedge clk);

        // 2) streaming with resp_ready high
        for (int i = 0; i < 8; i++) begin
            cycle("stream", 1'b1, BASE + 32'(4 * i), 1'b1);
            chk("stream.occupancy", 64'(q.size() <= 1), 64'd1);
        end
        cycle("stream.drain", 1'b0, '0, 1'b1);
        chk("stream.empty", 64'(resp_valid), 64'd0);

        // 3) backpressure: fill, hold third request, then drain in order
        cycle("bp0", 1'b1, BASE + 32'd40, 1'b0);
        cycle("bp1", 1'b1, BASE + 32'd44, 1'b0);
        chk("bp.full.req_ready", 64'(req_ready), 64'd0);
        cycle("bp2", 1'b1, BASE + 32'd48, 1'b0);
        chk("bp.k0", 64'(resp_instr), 64'(IBASE + 32'd10));
        chk("bp.fullpop.req_ready", 64'(req_ready), 64'd0);
        cycle("bp3", 1'b1, BASE + 32'd48, 1'b1);
        chk("bp.k1", 64'(resp_instr), 64'(IBASE + 32'd11));
        chk("bp.freed.req_ready", 64'(req_ready), 64'd1);
        cycle("bp4", 1'b1, BASE + 32'd48, 1'b1);
        chk("bp.k2", 64'(resp_instr), 64'(IBASE + 32'd12));
        cycle("bp5", 1'b0, '0, 1'b1);
        cycle("bp6", 1'b0, '0, 1'b1);

        // 4) misaligned and out-of-range fetches
        cycle("flt0", 1'b1, BASE + 32'd2, 1'b0);
`ifdef PROGMEM_ERR_TRAP_EN
        chk("flt.mis.err", 64'(resp_err), 64'd1);
        chk("flt.mis.instr", 64'(resp_instr), 64'd0);
`else
        chk("flt.mis.err", 64'(resp_err), 64'd0);
        chk("flt.mis.instr", 64'(resp_instr), 64'(IBASE));
`endif
        cycle("flt1", 1'b0, '0, 1'b1);
        cycle("flt2", 1'b1, BASE + 32'(4 * DEPTH), 1'b0);
`ifdef PROGMEM_ERR_TRAP_EN
        chk("flt.oor.err", 64'(resp_err), 64'd1);
        chk("flt.oor.instr", 64'(resp_instr), 64'd0);
`else
        chk("flt.oor.err", 64'(resp_err), 64'd0);
        chk("flt.oor.instr", 64'(resp_instr), 64'(IBASE));
`endif
        cycle("flt3", 1'b0, '0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel < 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (sel < 9) a = BASE + 32'(4 * $urandom_range(DEPTH, 4 * DEPTH));
            else              a = $urandom;
            cycle("rnd", 1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) cycle("rnd.drain", 1'b0, '0, 1'b1);

        // 5) reset with two entries queued
        cycle("rq0", 1'b1, BASE + 32'd8, 1'b0);
        cycle("rq1", 1'b1, BASE + 32'd12, 1'b0);
        chk("rq.full", 64'(resp_valid && !req_ready), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rq.rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rq.rst.instr", 64'(resp_instr), 64'd0);
        chk("rq.rst.addr", 64'(resp_addr), 64'd0);
        chk("rq.rst.err", 64'(resp_err), 64'd0);
        chk("rq.rst.req_ready", 64'(req_ready), 64'd0);
        q.delete();
        exp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle("post0", 1'b0, '0, 1'b1);
        cycle("post1", 1'b0, '0, 1'b1);
        chk("post.no_old", 64'(resp_valid), 64'd0);
        cycle("post2", 1'b1, BASE + 32'd20, 1'b0);
        chk("post.new.instr", 64'(resp_instr), 64'(IBASE + 32'd5));
        chk("post.new.addr", 64'(resp_addr), 64'(BASE + 32'd20));
        cycle("post3", 1'b0, '0, 1'b1);
        cycle("post4", 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
